ring_buffer_fifo: RTL and testbench
===================================

// Module: ring_buffer_fifo
// PURPOSE
//  Parametrised circular sample buffer: stores WIDTH-bit words at DEPTH slots, sequential write/read pointers
//  wrapping at DEPTH-1 (non-power-of-2 DEPTH legal). Successor to the fixed 8x10 sequential store: adds
//  push/pop handshake, full/empty/count, error pulses, clear. Sits between ui_in/uio_in and uo_out/uio_out of TT top.
// PARAMETERS
//  WIDTH  8   data word width, >=1
//  DEPTH  10  number of slots, >=2; pointer wrap at DEPTH-1 explicit (no power-of-2 assumption)
//  (localparams: AW=$clog2(DEPTH), CW=$clog2(DEPTH+1))
// PORTS
//  clk         in   1      single clock, all state on posedge
//  rst_n       in   1      reset, synchronous, active-low
//  clr_i       in   1      synchronous flush: pointers/count to 0, memory contents untouched
//  push_i      in   1      write request, wr_data_i captured when accepted
//  wr_data_i   in   WIDTH  write data
//  pop_i       in   1      read request
//  rd_data_o   out  WIDTH  registered read data, valid when rd_valid_o=1
//  rd_valid_o  out  1      1-cycle pulse, cycle after an accepted pop
//  full_o      out  1      count==DEPTH
//  empty_o     out  1      count==0
//  count_o     out  CW     occupied slots, 0..DEPTH
//  overflow_o  out  1      1-cycle pulse: push while full (rejected, or oldest dropped if overwrite)
//  underflow_o out  1      1-cycle pulse: pop while empty (ignored)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=count=0; rd_data_o=0, rd_valid_o=0, overflow_o=0, underflow_o=0;
//    empty_o=1, full_o=0. Applies mid-operation; memory not cleared; pending push/pop that cycle discarded.
//  - Priority per cycle: rst_n > clr_i > push/pop. clr_i: same as reset except rd_data_o holds its value.
//  - Accepted push: mem[wr_ptr]<=wr_data_i; wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1.
//  - Accepted pop: rd_data_o<=mem[rd_ptr]; rd_valid_o<=1 next cycle; rd_ptr wraps same as wr_ptr. Latency 1.
//  - Pop accepted iff count>0 (flags from state before the edge; no write-through bypass when empty).
//  - Push accepted iff count<DEPTH, OR full with simultaneous accepted pop (slot freed same cycle).
//  - Count: +1 push only, -1 pop only, unchanged both or neither. full_o/empty_o/count_o combinational from count.
//  - Empty + push + pop: pop -> underflow_o pulse, push accepted, count 0->1.
//  - Full + push + pop: both accepted, count stays DEPTH, no overflow.
//  - Full + push, no pop: see CONFIGURATION; overflow_o pulses in both builds.
//  - Read/write same slot same cycle only when full+push+pop: read returns old word (read-before-write).
//  - No X propagation: rd_data_o only ever loads written slots or reset value.
// CONFIGURATION
//  RBUF_OVERWRITE_EN defined: push while full (no pop) writes mem[wr_ptr], advances wr_ptr AND rd_ptr
//    (oldest word dropped), count stays DEPTH, overflow_o=1.
//  RBUF_OVERWRITE_EN undefined: push while full (no pop) rejected, memory/pointers unchanged, overflow_o=1.
// STRUCTURE
//  - Package rbuf_pkg: default WIDTH/DEPTH constants, function next_ptr(ptr, depth) with explicit wrap.
//  - Sub-module rbuf_wrap_ctr (AW-bit counter, inc_i, clr_i, wraps at DEPTH-1), instantiated for wr_ptr and rd_ptr.
//  - Storage: reg array [0:DEPTH-1], no reset on array (maps to latch/DFF RAM).
// TESTING (WIDTH=8, DEPTH=10)
//  1 Reset: rst_n=0 one cycle with push_i=1 -> count_o=0, empty_o=1, rd_valid_o=0, rd_data_o=8'h00.
//  2 Fill/drain wrap: push 0x01..0x0A -> full_o=1,count=10; pop x10 -> 0x01..0x0A in order, each 1 cycle after pop;
//    repeat with 15 push / 15 interleaved pops -> pointers wrap past 9, order preserved.
//  3 Overflow: full, push 0xAA no pop -> overflow_o pulse; without macro next pops 0x01..; with RBUF_OVERWRITE_EN
//    pops 0x02..0x0A,0xAA.
//  4 Underflow+simultaneous: empty, push 0x55+pop -> underflow_o pulse, count=1; next pop -> 0x55.
//    Full, push 0x77+pop -> count=10, no overflow, popped word = oldest.
//  5 Clear/reset mid-op: count=6, clr_i=1 with push -> count=0, empty_o=1; next push 0x33, pop -> 0x33.
//  6 Random push/pop 2000 cycles vs queue model -> data, count_o, flags and pulses match every cycle.

Source files
------------

// File: rtl/rbuf_pkg.sv
// Shared constants and pointer-wrap helper for the ring buffer FIFO.
package rbuf_pkg;

    localparam int unsigned RBUF_WIDTH = 8;
    localparam int unsigned RBUF_DEPTH = 10;

    // Explicit wrap at depth-1 so non-power-of-2 depths work
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : rbuf_pkg

// File: rtl/ring_buffer_fifo_if.sv
// Push/pop handshake, clear and status bundle of the ring buffer FIFO.
interface ring_buffer_fifo_if
    import rbuf_pkg::*;
#(
    parameter int unsigned WIDTH = RBUF_WIDTH,
    parameter int unsigned DEPTH = RBUF_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             clr_i;
    logic             push_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             pop_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             full_o;
    logic             empty_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output clr_i, push_i, wr_data_i, pop_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, push_i, wr_data_i, pop_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

endinterface : ring_buffer_fifo_if

// File: rtl/rbuf_wrap_ctr.sv
// Slot pointer counting 0..DEPTH-1 and wrapping explicitly back to 0.
module rbuf_wrap_ctr
    import rbuf_pkg::*;
#(
    parameter  int unsigned DEPTH = RBUF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= AW'(next_ptr(32'(r_ptr), DEPTH));
        end
    end

    assign ptr_o = r_ptr;

endmodule : rbuf_wrap_ctr

// File: rtl/ring_buffer_fifo.sv
// Parametrised circular sample buffer with push/pop handshake, status and error pulses.
// Build option RBUF_OVERWRITE_EN: push while full drops the oldest word instead of being rejected.
module ring_buffer_fifo
    import rbuf_pkg::*;
#(
    parameter int unsigned WIDTH = RBUF_WIDTH,
    parameter int unsigned DEPTH = RBUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    ring_buffer_fifo_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic [CW-1:0]    r_count;

    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_overflow;
    logic             w_underflow;
    logic             w_drop_oldest;
    logic             w_wr_inc;
    logic             w_rd_inc;
    logic [CW-1:0]    w_count_nxt;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop_ok    = bus.pop_i && !w_empty;
    // A pop from a full buffer frees the slot the push needs in the same cycle
    assign w_push_ok   = bus.push_i && (!w_full || w_pop_ok);
    assign w_overflow  = bus.push_i && w_full && !bus.pop_i;
    assign w_underflow = bus.pop_i && w_empty;

`ifdef RBUF_OVERWRITE_EN
    assign w_drop_oldest = w_overflow;
`else
    assign w_drop_oldest = 1'b0;
`endif

    assign w_wr_inc = w_push_ok || w_drop_oldest;
    assign w_rd_inc = w_pop_ok || w_drop_oldest;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    rbuf_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.clr_i),
        .inc_i (w_wr_inc),
        .ptr_o (w_wr_ptr)
    );

    rbuf_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.clr_i),
        .inc_i (w_rd_inc),
        .ptr_o (w_rd_ptr)
    );

    // Storage is never reset; writes are suppressed during reset and clear
    always_ff @(posedge clk) begin
        if (rst_n && !bus.clr_i && w_wr_inc) begin
            r_mem[w_wr_ptr] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr_i) begin
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
            if (w_pop_ok) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end
        end
    end

    assign bus.rd_data_o   = r_rd_data;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.full_o      = w_full;
    assign bus.empty_o     = w_empty;
    assign bus.count_o     = r_count;
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;

endmodule : ring_buffer_fifo

// File: tb/tb_ring_buffer_fifo.sv
// Bench for ring_buffer_fifo: queue reference model checked every cycle plus directed literal checks.
module tb_ring_buffer_fifo;

    localparam int unsigned W = 8;
    localparam int unsigned D = 10;

    logic clk;
    logic rst_n;

    ring_buffer_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    ring_buffer_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of stored words
    logic [W-1:0] q [$];
    logic [W-1:0] m_rd_data = '0;
    logic         m_valid   = 1'b0;
    logic         m_ovf     = 1'b0;
    logic         m_unf     = 1'b0;
    logic         chk_en    = 1'b0;

    always @(posedge clk) begin
        int unsigned sz;
        sz = q.size();
        chk_en = 1'b1;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_rd_data = '0;
        end else if (bus.clr_i) begin
            q.delete();
        end else begin
            if (bus.pop_i) begin
                if (sz == 0) begin
                    m_unf = 1'b1;
                end else begin
                    m_rd_data = q.pop_front();
                    m_valid = 1'b1;
                end
            end
            if (bus.push_i) begin
                if (sz < D || bus.pop_i) begin
                    q.push_back(bus.wr_data_i);
                end else begin
                    m_ovf = 1'b1;
`ifdef RBUF_OVERWRITE_EN
                    void'(q.pop_front());
                    q.push_back(bus.wr_data_i);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count",     32'(bus.count_o),     32'(q.size()));
            check("full",      32'(bus.full_o),      32'(q.size() == D));
            check("empty",     32'(bus.empty_o),     32'(q.size() == 0));
            check("rd_valid",  32'(bus.rd_valid_o),  32'(m_valid));
            check("rd_data",   32'(bus.rd_data_o),   32'(m_rd_data));
            check("overflow",  32'(bus.overflow_o),  32'(m_ovf));
            check("underflow", 32'(bus.underflow_o), 32'(m_unf));
        end
    end

    // Drive one cycle of inputs; returns at the following negedge
    task automatic step(input logic p, input logic [W-1:0] d, input logic pp, input logic c);
        bus.push_i    = p;
        bus.wr_data_i = d;
        bus.pop_i     = pp;
        bus.clr_i     = c;
        @(negedge clk);
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        bus.clr_i  = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [W-1:0] exp);
        step(1'b0, '0, 1'b1, 1'b0);
        check({name, "_valid"}, 32'(bus.rd_valid_o), 32'd1);
        check(name, 32'(bus.rd_data_o), 32'(exp));
    endtask

    logic [W-1:0] exp_ovf [0:D-1];

    initial begin
        rst_n         = 1'b0;
        bus.clr_i     = 1'b0;
        bus.push_i    = 1'b0;
        bus.pop_i     = 1'b0;
        bus.wr_data_i = '0;

        // Reset with a push pending
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("rst_count", 32'(bus.count_o),    32'd0);
        check("rst_empty", 32'(bus.empty_o),    32'd1);
        check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_data",  32'(bus.rd_data_o),  32'h00);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill and drain
        for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        check("fill_full",  32'(bus.full_o),  32'd1);
        check("fill_count", 32'(bus.count_o), 32'd10);
        for (int i = 1; i <= 10; i++) pop_expect("drain", W'(i));
        check("drain_empty", 32'(bus.empty_o), 32'd1);

        // Interleaved traffic wraps both pointers past the last slot
        step(1'b1, 8'h10, 1'b0, 1'b0);
        for (int i = 1; i < 15; i++) begin
            step(1'b1, W'(8'h10 + i), 1'b1, 1'b0);
            check("wrap_data", 32'(bus.rd_data_o), 32'(8'h10 + i - 1));
        end
        pop_expect("wrap_last", 8'h1E);

        // Push while full
        for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_pulse", 32'(bus.overflow_o), 32'd1);
        check("ovf_count", 32'(bus.count_o),    32'd10);
        for (int i = 0; i < 10; i++) begin
`ifdef RBUF_OVERWRITE_EN
            exp_ovf[i] = (i == 9) ? 8'hAA : W'(i + 2);
`else
            exp_ovf[i] = W'(i + 1);
`endif
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("ovf_clear", 32'(bus.overflow_o), 32'd0);
        for (int i = 0; i < 10; i++) pop_expect("ovf_drain", exp_ovf[i]);

        // Empty with push+pop: underflow, push still lands
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("unf_pulse", 32'(bus.underflow_o), 32'd1);
        check("unf_count", 32'(bus.count_o),     32'd1);
        check("unf_valid", 32'(bus.rd_valid_o),  32'd0);
        pop_expect("unf_word", 8'h55);

        // Full with push+pop: both accepted, oldest word returned
        for (int i = 1; i <= 10; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("fpp_count", 32'(bus.count_o),    32'd10);
        check("fpp_ovf",   32'(bus.overflow_o), 32'd0);
        check("fpp_data",  32'(bus.rd_data_o),  32'h61);
        for (int i = 2; i <= 10; i++) pop_expect("fpp_drain", W'(8'h60 + i));
        pop_expect("fpp_tail", 8'h77);

        // Clear mid-operation with a pending push
        for (int i = 1; i <= 6; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        check("pre_clr_count", 32'(bus.count_o), 32'd6);
        step(1'b1, 8'hCC, 1'b0, 1'b1);
        check("clr_count", 32'(bus.count_o),   32'd0);
        check("clr_empty", 32'(bus.empty_o),   32'd1);
        check("clr_hold",  32'(bus.rd_data_o), 32'h77);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        pop_expect("clr_after", 8'h33);

        // Reset mid-operation
        for (int i = 1; i <= 3; i++) step(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 8'h99, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("mrst_count", 32'(bus.count_o),   32'd0);
        check("mrst_data",  32'(bus.rd_data_o), 32'h00);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        pop_expect("mrst_after", 8'h3C);

        // Random traffic, biased toward filling then toward draining
        for (int n = 0; n < 2000; n++) begin
            logic p, pp, c;
            if (n < 1000) begin
                p  = ($urandom_range(0, 3) != 0);
                pp = ($urandom_range(0, 1) != 0);
            end else begin
                p  = ($urandom_range(0, 1) != 0);
                pp = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 255) != 0);
            step(p, W'($urandom), pp, c);
        end
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ring_buffer_fifo
